// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Definitions shared by the Sobel window controller and the Sobel core.
//   - Controller state encoding (S_IDLE / S_FILL / S_RUN).
//   - Window tap indices P0..P8. Packed windows carry p0 in the LSBs and p8 in
//     the MSBs. p0..p2 form the top row, p3..p5 the middle row (p4 is the
//     centre) and p6..p8 the bottom row, each row ordered left to right.
//   - tap_lsb(): bit offset of a tap inside a packed window.
// -----------------------------------------------------------------------------
package sobel_pkg;

  typedef logic [1:0] sobel_state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;
  localparam int P4 = 4;
  localparam int P5 = 5;
  localparam int P6 = 6;
  localparam int P7 = 7;
  localparam int P8 = 8;

  localparam int WIN_TAPS = 9;

  // LSB position of tap p in a window packed at bw bits per tap.
  function automatic int tap_lsb(input int p, input int bw);
    return p * bw;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// -----------------------------------------------------------------------------
// sobel_line_buffer
// One image line of pixel storage. The read is combinational and the write is
// synchronous, both at the same address, so a read in the cycle of a write
// returns the old contents (read-before-write). The controller chains two of
// these so that the older line moves down one buffer on every accepted pixel.
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   addr   in   ADDR_W   column address (read and write)
//   wdata  in   BIT_WIDTH  data written at addr
//   rdata  out  BIT_WIDTH  current contents at addr
// -----------------------------------------------------------------------------
module sobel_line_buffer #(
  parameter int BIT_WIDTH = 8,
  parameter int IMG_W     = 640,
  parameter int ADDR_W    = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [BIT_WIDTH-1:0] wdata,
  output logic [BIT_WIDTH-1:0] rdata
);

  logic [BIT_WIDTH-1:0] mem [IMG_W];

  assign rdata = mem[addr];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_window_ctrl
// Front-end sequencer for the Sobel edge datapath. Tracks raster position of an
// unstallable pixel stream, keeps the two previous lines in line buffers and
// presents one registered 3x3 window per interior pixel, one cycle after the
// pixel that completes it is accepted.
//
// Ports:
//   clk        in   pipeline clock
//   rst        in   synchronous active-high reset
//   in_valid   in   pixel present this cycle
//   in_sof     in   (qualified by in_valid) this pixel is row 0, col 0
//   in_pixel   in   BIT_WIDTH luminance sample
//   out_valid  out  out_win valid this cycle
//   out_win    out  9*BIT_WIDTH window, p0 in the LSBs .. p8 in the MSBs
//   out_row    out  ROW_W centre row of out_win
//   out_col    out  COL_W centre column of out_win
//   out_eof    out  high with the last window of a frame
//   busy       out  high while a frame is in progress
//
// Optional build macro SOBEL_WINDOW_CTRL_ERR_EN adds:
//   err_resync out  sticky flag, set on in_sof in the middle of a frame
//   err_count  out  8-bit saturating count of mid-frame in_sof events
//   frame_cnt  out  16-bit wrapping count of out_eof pulses
// -----------------------------------------------------------------------------
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int COL_W     = 10,
  parameter int ROW_W     = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [BIT_WIDTH-1:0]   in_pixel,
  output logic                   out_valid,
  output logic [9*BIT_WIDTH-1:0] out_win,
  output logic [ROW_W-1:0]       out_row,
  output logic [COL_W-1:0]       out_col,
  output logic                   out_eof,
  output logic                   busy
`ifdef SOBEL_WINDOW_CTRL_ERR_EN
  ,
  output logic                   err_resync,
  output logic [7:0]             err_count,
  output logic [15:0]            frame_cnt
`endif
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [1:0]           state_reg, state_next;
  logic [ROW_W-1:0]     row_reg, row_next;
  logic [COL_W-1:0]     col_reg, col_next;

  logic                 out_valid_reg;
  logic                 out_eof_reg;
  logic [ROW_W-1:0]     out_row_reg;
  logic [COL_W-1:0]     out_col_reg;

  logic                 accept;
  logic [ROW_W-1:0]     cur_row;
  logic [COL_W-1:0]     cur_col;
  logic                 emit;
  logic                 last_pix;

  logic [BIT_WIDTH-1:0] lb0_rd, lb1_rd;
  logic [BIT_WIDTH-1:0] new_col [3];

  // In idle only a start-of-frame pixel is taken; elsewhere every valid pixel.
  assign accept = in_valid && ((state_reg != S_IDLE) || in_sof);

  // A start-of-frame pixel is (0,0) regardless of where the counters were.
  assign cur_row = in_sof ? '0 : row_reg;
  assign cur_col = in_sof ? '0 : col_reg;

  assign last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  // Columns 0 and 1 still hold the previous line's right edge, so only
  // windows completed at column >= 2 (and row >= 2) are interior.
  assign emit = accept && !in_sof &&
                (row_reg >= ROW_W'(2)) && (col_reg >= COL_W'(2));

  // ---------------------------------------------------------------------------
  // Position / state sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    if (accept) begin
      state_next = in_sof ? S_FILL : state_reg;
      if (cur_col == COL_LAST) begin
        col_next = '0;
        if (cur_row == ROW_LAST) begin
          // Frame complete: the row counter never wraps, it restarts here.
          row_next   = '0;
          state_next = S_IDLE;
        end else begin
          row_next = cur_row + ROW_W'(1);
          if (cur_row == ROW_W'(1)) begin
            state_next = S_RUN;
          end
        end
      end else begin
        col_next = cur_col + COL_W'(1);
        row_next = cur_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      row_reg       <= '0;
      col_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_eof_reg   <= 1'b0;
      out_row_reg   <= '0;
      out_col_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      out_valid_reg <= emit;
      out_eof_reg   <= emit && last_pix;
      if (emit) begin
        out_row_reg <= row_reg - ROW_W'(1);
        out_col_reg <= col_reg - COL_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: lb0 holds the previous line, lb1 the one before. On accept
  // the old lb0 entry slides into lb1 while the new pixel lands in lb0.
  // ---------------------------------------------------------------------------
  sobel_line_buffer #(
    .BIT_WIDTH (BIT_WIDTH),
    .IMG_W     (IMG_W),
    .ADDR_W    (COL_W)
  ) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (in_pixel),
    .rdata (lb0_rd)
  );

  sobel_line_buffer #(
    .BIT_WIDTH (BIT_WIDTH),
    .IMG_W     (IMG_W),
    .ADDR_W    (COL_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Incoming right-hand column, top to bottom.
  assign new_col[0] = lb1_rd;
  assign new_col[1] = lb0_rd;
  assign new_col[2] = in_pixel;

  // ---------------------------------------------------------------------------
  // 3x3 window: each row is a three-tap shift register fed from new_col.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      localparam int BASE = (gi == 0) ? P0 : ((gi == 1) ? P3 : P6);
      logic [BIT_WIDTH-1:0] tap_reg [3];

      always_ff @(posedge clk) begin
        if (rst) begin
          tap_reg[0] <= '0;
          tap_reg[1] <= '0;
          tap_reg[2] <= '0;
        end else if (accept) begin
          tap_reg[0] <= tap_reg[1];
          tap_reg[1] <= tap_reg[2];
          tap_reg[2] <= new_col[gi];
        end
      end

      assign out_win[tap_lsb(BASE,     BIT_WIDTH) +: BIT_WIDTH] = tap_reg[0];
      assign out_win[tap_lsb(BASE + 1, BIT_WIDTH) +: BIT_WIDTH] = tap_reg[1];
      assign out_win[tap_lsb(BASE + 2, BIT_WIDTH) +: BIT_WIDTH] = tap_reg[2];
    end
  endgenerate

  assign out_valid = out_valid_reg;
  assign out_eof   = out_eof_reg;
  assign out_row   = out_row_reg;
  assign out_col   = out_col_reg;
  assign busy      = (state_reg != S_IDLE);

`ifdef SOBEL_WINDOW_CTRL_ERR_EN
  // ---------------------------------------------------------------------------
  // Resync / frame statistics
  // ---------------------------------------------------------------------------
  logic        err_resync_reg;
  logic [7:0]  err_count_reg;
  logic [15:0] frame_cnt_reg;
  logic        resync_hit;

  assign resync_hit = accept && in_sof && (state_reg != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_resync_reg <= 1'b0;
      err_count_reg  <= '0;
      frame_cnt_reg  <= '0;
    end else begin
      if (resync_hit) begin
        err_resync_reg <= 1'b1;
        if (err_count_reg != 8'hFF) begin
          err_count_reg <= err_count_reg + 8'd1;
        end
      end
      if (out_eof_reg) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign err_resync = err_resync_reg;
  assign err_count  = err_count_reg;
  assign frame_cnt  = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_ctrl
// Scoreboard bench for sobel_window_ctrl on a 5x4 image. The driver keeps a
// frame-level model (raster position plus a copy of the current frame's
// pixels) and pushes every expected window into a queue; a negedge monitor
// pops and compares whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_sobel_window_ctrl;

  localparam int BW  = 8;
  localparam int W   = 5;
  localparam int H   = 4;
  localparam int CW  = 3;
  localparam int RW  = 3;
  localparam int WPF = (H - 2) * (W - 2);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_sof;
  logic [BW-1:0]   in_pixel;
  logic            out_valid;
  logic [9*BW-1:0] out_win;
  logic [RW-1:0]   out_row;
  logic [CW-1:0]   out_col;
  logic            out_eof;
  logic            busy;
`ifdef SOBEL_WINDOW_CTRL_ERR_EN
  logic            err_resync;
  logic [7:0]      err_count;
  logic [15:0]     frame_cnt;
`endif

  sobel_window_ctrl #(
    .BIT_WIDTH (BW),
    .IMG_W     (W),
    .IMG_H     (H),
    .COL_W     (CW),
    .ROW_W     (RW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_win   (out_win),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_eof   (out_eof),
    .busy      (busy)
`ifdef SOBEL_WINDOW_CTRL_ERR_EN
    ,
    .err_resync(err_resync),
    .err_count (err_count),
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9*BW-1:0] win;
    int              row;
    int              col;
    bit              eof;
    int              cyc;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  bit exp_busy = 1'b0;

  // Reference model state
  logic [BW-1:0] img [H][W];
  bit  m_busy   = 1'b0;
  int  m_r      = 0;
  int  m_c      = 0;
  int  m_err    = 0;
  bit  m_resync = 1'b0;
  int  m_eofs   = 0;

  int  win_seen = 0;
  int  eof_seen = 0;
  bit  first_seen = 1'b0;
  logic [9*BW-1:0] first_win = '0;

  task automatic check(input string name, input logic [9*BW-1:0] act,
                       input logic [9*BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: position follows raster rules; every interior
  // pixel yields the 3x3 block of this frame ending at it.
  task automatic model_step(input bit v, input bit sof, input logic [BW-1:0] pix,
                            input bit r);
    exp_t e;
    if (r) begin
      m_busy = 1'b0; m_r = 0; m_c = 0;
      m_err = 0; m_resync = 1'b0; m_eofs = 0;
      return;
    end
    if (!v) return;
    if (sof) begin
      if (m_busy) begin
        m_resync = 1'b1;
        if (m_err < 255) m_err++;
      end
      m_busy = 1'b1; m_r = 0; m_c = 0;
    end else if (!m_busy) begin
      return;
    end
    img[m_r][m_c] = pix;
    if (m_r >= 2 && m_c >= 2) begin
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          e.win[(3*dr + dc)*BW +: BW] = img[m_r-2+dr][m_c-2+dc];
      e.row = m_r - 1;
      e.col = m_c - 1;
      e.eof = (m_r == H-1) && (m_c == W-1);
      e.cyc = cyc + 1;
      if (e.eof) m_eofs++;
      q.push_back(e);
    end
    if (m_c == W-1) begin
      m_c = 0;
      if (m_r == H-1) begin
        m_r = 0; m_busy = 1'b0;
      end else begin
        m_r++;
      end
    end else begin
      m_c++;
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic drive(input bit v, input bit sof, input logic [BW-1:0] pix,
                       input bit r);
    in_valid = v; in_sof = sof; in_pixel = pix; rst = r;
    model_step(v, sof, pix, r);
    @(posedge clk);
    #1;
    exp_busy = m_busy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
  endtask

  // gapmode: 0 none, 1 one idle cycle between pixels, 2 random idle cycles.
  task automatic frame(input int npix, input int gapmode, input bit ramp);
    for (int i = 0; i < npix; i++) begin
      int r;
      int c;
      r = i / W;
      c = i % W;
      if (gapmode == 1 && i > 0) idle(1);
      if (gapmode == 2) begin
        while ($urandom_range(0, 3) == 0) idle(1);
      end
      drive(1'b1, i == 0, ramp ? 8'(16*r + c) : 8'($urandom), 1'b0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("busy", 72'(busy), 72'(exp_busy));
      if (out_eof && !out_valid) check("eof_qualified", 72'(out_eof), 72'(0));
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_window: got centre (%0d,%0d), expected no window",
                   out_row, out_col);
        end else begin
          e = q.pop_front();
          check("win", out_win, e.win);
          check("row", 72'(out_row), 72'(e.row));
          check("col", 72'(out_col), 72'(e.col));
          check("eof", 72'(out_eof), 72'(e.eof));
          check("latency_cycle", 72'(cyc), 72'(e.cyc));
          win_seen++;
          if (out_eof) eof_seen++;
          if (!first_seen) begin
            first_seen = 1'b1;
            first_win  = out_win;
          end
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_out_valid"}, 72'(out_valid), 72'(0));
    check({tag, "_out_win"},   out_win,        72'(0));
    check({tag, "_out_row"},   72'(out_row),   72'(0));
    check({tag, "_out_col"},   72'(out_col),   72'(0));
    check({tag, "_out_eof"},   72'(out_eof),   72'(0));
    check({tag, "_busy"},      72'(busy),      72'(0));
`ifdef SOBEL_WINDOW_CTRL_ERR_EN
    check({tag, "_err_resync"}, 72'(err_resync), 72'(0));
    check({tag, "_err_count"},  72'(err_count),  72'(0));
    check({tag, "_frame_cnt"},  72'(frame_cnt),  72'(0));
`endif
  endtask

  task automatic check_err(input string tag);
`ifdef SOBEL_WINDOW_CTRL_ERR_EN
    check({tag, "_err_resync"}, 72'(err_resync), 72'(m_resync));
    check({tag, "_err_count"},  72'(err_count),  72'(m_err));
    check({tag, "_frame_cnt"},  72'(frame_cnt),  72'(m_eofs % 65536));
`endif
    check({tag, "_drained"}, 72'(q.size()), 72'(0));
  endtask

  initial begin
    int w0;
    int e0;
    logic [9*BW-1:0] first_exp;
    first_exp = 72'h22_21_20_12_11_10_02_01_00;

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    mon_en = 1'b1;

    // Ramp frame, no gaps.
    w0 = win_seen; e0 = eof_seen;
    frame(W*H, 0, 1'b1);
    idle(3);
    check("ramp_first_win", first_win, first_exp);
    check("ramp_win_count", 72'(win_seen - w0), 72'(WPF));
    check("ramp_eof_count", 72'(eof_seen - e0), 72'(1));
    check_err("ramp");

    // Idle pixels without in_sof are ignored, then a normal frame.
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'($urandom), 1'b0);
    check("idle_no_windows", 72'(q.size()), 72'(0));
    frame(W*H, 0, 1'b0);
    idle(3);
    check_err("after_idle");

    // Same ramp frame with gaps every other cycle.
    w0 = win_seen;
    frame(W*H, 1, 1'b1);
    idle(3);
    check("gap_win_count", 72'(win_seen - w0), 72'(WPF));

    // Mid-frame in_sof at (2,3), followed by a full frame with random gaps.
    e0 = eof_seen;
    frame(2*W + 3, 0, 1'b0);
    frame(W*H, 2, 1'b0);
    idle(3);
    check("resync_eof_count", 72'(eof_seen - e0), 72'(1));
    check_err("resync");

    // Reset while pixel (3,2) is presented.
    frame(3*W + 2, 0, 1'b0);
    drive(1'b1, 1'b0, 8'($urandom), 1'b1);
    check_outputs_zero("midreset");
    w0 = win_seen;
    frame(W*H, 0, 1'b0);
    idle(3);
    check("post_reset_win_count", 72'(win_seen - w0), 72'(WPF));

    // Back-to-back frames from a clean reset.
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    w0 = win_seen; e0 = eof_seen;
    frame(W*H, 0, 1'b0);
    frame(W*H, 0, 1'b0);
    idle(3);
    check("b2b_win_count", 72'(win_seen - w0), 72'(2*WPF));
    check("b2b_eof_count", 72'(eof_seen - e0), 72'(2));
    check_err("b2b");

    // Random frames, gaps and occasional aborted frames.
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 3) == 0) frame($urandom_range(1, W*H-1), $urandom_range(0, 2), 1'b0);
      frame(W*H, $urandom_range(0, 2), 1'b0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    idle(5);
    check_err("random");

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
